// File: rtl/multi_crop_extractor.sv
// multi_crop_extractor: unpacks wide AXI-Stream frame beats to one pixel per cycle, captures
// NUM_CROPS windows into per-crop RAMs and drains the enabled ones in index order. Option: CROP_SUM_EN.
module multi_crop_extractor #(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned BEAT_W    = 256,
  parameter int unsigned IN_ROWS   = 20,
  parameter int unsigned IN_COLS   = 32,
  parameter int unsigned OUT_ROWS  = 4,
  parameter int unsigned OUT_COLS  = 4,
  parameter int unsigned NUM_CROPS = 5
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     ap_start,
  output logic                                     ap_idle,
  output logic                                     ap_ready,
  output logic                                     ap_done,
  input  logic [NUM_CROPS-1:0]                     crop_en,
  input  logic [NUM_CROPS*$clog2(IN_COLS)-1:0]     crop_x0,
  input  logic [NUM_CROPS*$clog2(IN_ROWS)-1:0]     crop_y0,
  output logic [NUM_CROPS-1:0]                     crop_err,
`ifdef CROP_SUM_EN
  output logic [NUM_CROPS*(PIX_W+$clog2(OUT_ROWS*OUT_COLS))-1:0] crop_sum,
`endif
  input  logic                                     s_axis_tvalid,
  output logic                                     s_axis_tready,
  input  logic [BEAT_W-1:0]                        s_axis_tdata,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic [PIX_W-1:0]                         m_axis_tdata,
  output logic                                     m_axis_tlast,
  output logic [((NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1)-1:0] m_crop_idx
);
  localparam int unsigned PPB    = BEAT_W / PIX_W;
  localparam int unsigned XW     = $clog2(IN_COLS);
  localparam int unsigned YW     = $clog2(IN_ROWS);
  localparam int unsigned BUF_D  = OUT_ROWS * OUT_COLS;
  localparam int unsigned AW     = (BUF_D > 1) ? $clog2(BUF_D) : 1;
  localparam int unsigned IW     = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1;
  localparam int unsigned LW     = (PPB > 1) ? $clog2(PPB) : 1;
  localparam int unsigned NBEATS = IN_ROWS * IN_COLS / PPB;
  localparam int unsigned BW     = $clog2(NBEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [NUM_CROPS-1:0] en_q, crop_err_q, err_new;
  logic [XW-1:0]        x0_q [NUM_CROPS];
  logic [YW-1:0]        y0_q [NUM_CROPS];
  logic [BEAT_W-1:0]    beat_q;
  logic                 full_q, ap_ready_q;
  logic [LW-1:0]        lane_q;
  logic [BW-1:0]        beat_cnt_q;
  logic [YW-1:0]        row_q;
  logic [XW-1:0]        col_q;
  logic [AW-1:0]        rd_addr_q;
  logic [IW-1:0]        crop_ptr_q, oidx_q, first_idx, nxt_idx;
  logic                 more_q, ovalid_q, olast_q, nxt_found;
  logic [NUM_CROPS-1:0] we;
  logic [AW-1:0]        waddr [NUM_CROPS];
  logic [PIX_W-1:0]     rdata [NUM_CROPS];
  logic [PIX_W-1:0]     pix;
  logic start, unpack, last_lane, last_pix, accept, advance, rd_en, out_hs;

  assign start     = (state_q == S_IDLE) && ap_start;
  assign pix       = beat_q[32'(lane_q)*PIX_W +: PIX_W];
  assign unpack    = (state_q == S_CAPTURE) && full_q;
  assign last_lane = (lane_q == LW'(PPB - 1));
  assign last_pix  = unpack && (row_q == YW'(IN_ROWS - 1)) && (col_q == XW'(IN_COLS - 1));
  assign s_axis_tready = (state_q == S_CAPTURE) && (beat_cnt_q != BW'(NBEATS)) &&
                         (!full_q || last_lane);
  assign accept    = s_axis_tvalid && s_axis_tready;
  // The output register doubles as the RAM read register: a read is issued whenever it can be refilled.
  assign advance   = (state_q == S_DRAIN) && (!ovalid_q || m_axis_tready);
  assign rd_en     = advance && more_q;
  assign out_hs    = ovalid_q && m_axis_tready;

  always_comb begin
    err_new = '0;
    for (int unsigned i = 0; i < NUM_CROPS; i++) begin
      err_new[i] = (32'(crop_x0[i*XW +: XW]) + OUT_COLS > IN_COLS) ||
                   (32'(crop_y0[i*YW +: YW]) + OUT_ROWS > IN_ROWS);
    end
  end

  always_comb begin
    we = '0;
    for (int unsigned i = 0; i < NUM_CROPS; i++) begin
      we[i] = unpack && en_q[i] &&
              (32'(col_q) >= 32'(x0_q[i])) && (32'(col_q) < 32'(x0_q[i]) + OUT_COLS) &&
              (32'(row_q) >= 32'(y0_q[i])) && (32'(row_q) < 32'(y0_q[i]) + OUT_ROWS);
      waddr[i] = AW'((32'(row_q) - 32'(y0_q[i])) * OUT_COLS + (32'(col_q) - 32'(x0_q[i])));
    end
  end

  always_comb begin
    first_idx = '0;
    nxt_idx   = '0;
    nxt_found = 1'b0;
    for (int unsigned i = NUM_CROPS; i > 0; i--) begin
      if (en_q[i-1]) begin
        first_idx = IW'(i - 1);
        if ((i - 1) > 32'(crop_ptr_q)) begin
          nxt_idx   = IW'(i - 1);
          nxt_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ap_idle = 1'b0;
    ap_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_d = S_CAPTURE;
      end
      S_CAPTURE: if (last_pix) state_d = (|en_q) ? S_DRAIN : S_DONE;
      S_DRAIN:   if (out_hs && olast_q && !more_q) state_d = S_DONE;
      S_DONE: begin
        ap_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q <= '0; crop_err_q <= '0; beat_q <= '0; full_q <= 1'b0; ap_ready_q <= 1'b0;
      lane_q <= '0; beat_cnt_q <= '0; row_q <= '0; col_q <= '0;
      rd_addr_q <= '0; crop_ptr_q <= '0; oidx_q <= '0;
      more_q <= 1'b0; ovalid_q <= 1'b0; olast_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CROPS; i++) begin
        x0_q[i] <= '0;
        y0_q[i] <= '0;
      end
    end else begin
      ap_ready_q <= accept && (beat_cnt_q == BW'(NBEATS - 1));
      if (start) begin
        en_q       <= crop_en & ~err_new;
        crop_err_q <= err_new;
        beat_cnt_q <= '0;
        row_q      <= '0;
        col_q      <= '0;
        full_q     <= 1'b0;
        lane_q     <= '0;
        for (int unsigned i = 0; i < NUM_CROPS; i++) begin
          x0_q[i] <= crop_x0[i*XW +: XW];
          y0_q[i] <= crop_y0[i*YW +: YW];
        end
      end
      if (unpack) begin
        if (last_lane) full_q <= 1'b0;
        else           lane_q <= lane_q + LW'(1);
        if (col_q == XW'(IN_COLS - 1)) begin
          col_q <= '0;
          row_q <= row_q + YW'(1);
        end else begin
          col_q <= col_q + XW'(1);
        end
      end
      if (accept) begin
        beat_q     <= s_axis_tdata;
        full_q     <= 1'b1;
        lane_q     <= '0;
        beat_cnt_q <= beat_cnt_q + BW'(1);
      end
      if (last_pix) begin
        rd_addr_q  <= '0;
        crop_ptr_q <= first_idx;
        more_q     <= |en_q;
      end
      if (advance) begin
        ovalid_q <= more_q;
        if (more_q) begin
          oidx_q  <= crop_ptr_q;
          olast_q <= (rd_addr_q == AW'(BUF_D - 1));
          if (rd_addr_q == AW'(BUF_D - 1)) begin
            rd_addr_q  <= '0;
            crop_ptr_q <= nxt_idx;
            more_q     <= nxt_found;
          end else begin
            rd_addr_q <= rd_addr_q + AW'(1);
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CROPS; g++) begin : g_buf
    logic [PIX_W-1:0] mem [BUF_D];
    logic [PIX_W-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (we[g]) mem[waddr[g]] <= pix;
      if (rd_en) rd_q <= mem[rd_addr_q];
    end
    assign rdata[g] = rd_q;
  end

`ifdef CROP_SUM_EN
  localparam int unsigned SW = PIX_W + $clog2(BUF_D);
  logic [SW-1:0] sum_q [NUM_CROPS];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CROPS; i++) sum_q[i] <= '0;
    end else if (start) begin
      for (int unsigned i = 0; i < NUM_CROPS; i++) sum_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CROPS; i++)
        if (we[i]) sum_q[i] <= sum_q[i] + SW'(pix);
    end
  end
  always_comb begin
    crop_sum = '0;
    for (int unsigned i = 0; i < NUM_CROPS; i++) crop_sum[i*SW +: SW] = sum_q[i];
  end
`endif

  assign ap_ready      = ap_ready_q;
  assign crop_err      = crop_err_q;
  assign m_axis_tvalid = ovalid_q;
  assign m_axis_tdata  = ovalid_q ? rdata[oidx_q] : '0;
  assign m_axis_tlast  = ovalid_q & olast_q;
  assign m_crop_idx    = ovalid_q ? oidx_q : '0;
endmodule

// File: tb/tb_multi_crop_extractor.sv
// tb_multi_crop_extractor: directed and randomized frames checked against a window-extraction model.
module tb_multi_crop_extractor;
  localparam int PIX_W = 8, BEAT_W = 32, IN_ROWS = 8, IN_COLS = 8;
  localparam int OUT_ROWS = 2, OUT_COLS = 2, NUM_CROPS = 3;
  localparam int SW = PIX_W + $clog2(OUT_ROWS * OUT_COLS);

  logic clk = 1'b0, reset = 1'b0, ap_start = 1'b0;
  logic ap_idle, ap_ready, ap_done;
  logic [2:0]  crop_en = '0;
  logic [8:0]  crop_x0 = '0, crop_y0 = '0;
  logic [2:0]  crop_err;
  logic        s_axis_tvalid = 1'b0, s_axis_tready;
  logic [31:0] s_axis_tdata = '0;
  logic        m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
  logic [7:0]  m_axis_tdata;
  logic [1:0]  m_crop_idx;
`ifdef CROP_SUM_EN
  logic [3*SW-1:0] crop_sum;
`endif

  always #5 clk = ~clk;

  multi_crop_extractor #(
    .PIX_W(PIX_W), .BEAT_W(BEAT_W), .IN_ROWS(IN_ROWS), .IN_COLS(IN_COLS),
    .OUT_ROWS(OUT_ROWS), .OUT_COLS(OUT_COLS), .NUM_CROPS(NUM_CROPS)
  ) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_idle(ap_idle),
    .ap_ready(ap_ready), .ap_done(ap_done), .crop_en(crop_en),
    .crop_x0(crop_x0), .crop_y0(crop_y0), .crop_err(crop_err),
`ifdef CROP_SUM_EN
    .crop_sum(crop_sum),
`endif
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_crop_idx(m_crop_idx)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0, rdy_cnt = 0, done_cnt = 0, rdy_cyc = 0;
  logic [7:0]  img [64];
  logic [10:0] exp_q [$];
  logic [2:0]  exp_err;
  int          exp_sum [3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ap_ready === 1'b1) begin
      rdy_cnt++;
      rdy_cyc = cyc;
    end
    if (ap_done === 1'b1) done_cnt++;
  endtask

  task automatic fill_img(input bit rnd);
    for (int i = 0; i < 64; i++) img[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  // Expected stream: each usable crop's window in raster order, tagged {idx, last, pixel}.
  task automatic build_model(input logic [2:0] en, input logic [8:0] x0f, input logic [8:0] y0f);
    exp_q.delete();
    for (int i = 0; i < NUM_CROPS; i++) begin
      int x, y;
      x = int'(x0f[i*3 +: 3]);
      y = int'(y0f[i*3 +: 3]);
      exp_err[i] = (x + OUT_COLS > IN_COLS) || (y + OUT_ROWS > IN_ROWS);
      exp_sum[i] = 0;
      if (en[i] && !exp_err[i]) begin
        for (int r = 0; r < OUT_ROWS; r++)
          for (int c = 0; c < OUT_COLS; c++) begin
            logic [7:0] p;
            p = img[(y + r) * IN_COLS + x + c];
            exp_sum[i] += int'(p);
            exp_q.push_back({2'(i), (r == OUT_ROWS - 1) && (c == OUT_COLS - 1), p});
          end
      end
    end
  endtask

  // gap >= 0: fixed idle cycles before each beat; gap < 0: random 0..-gap.
  // bp_mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic run_frame(input logic [2:0] en, input logic [8:0] x0f, input logic [8:0] y0f,
                           input int gap, input int bp_mode, input int abort_after);
    int k, n_out;
    logic tr, stall, got_first, aborted;
    logic [10:0] held;
    build_model(en, x0f, y0f);
    rdy_cnt = 0;
    done_cnt = 0;
    check("idle_before_start", ap_idle, 1);
    check("s_tready_idle", s_axis_tready, 0);
    crop_en = en; crop_x0 = x0f; crop_y0 = y0f; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    crop_en = ~en; crop_x0 = ~x0f; crop_y0 = ~y0f;
    check("crop_err", crop_err, exp_err);
    check("idle_in_capture", ap_idle, 0);
    for (int b = 0; b < 16; b++) begin
      s_axis_tvalid = 1'b0;
      k = (gap >= 0) ? gap : int'($urandom_range(-gap, 0));
      repeat (k) tick();
      s_axis_tdata = {img[b*4+3], img[b*4+2], img[b*4+1], img[b*4]};
      s_axis_tvalid = 1'b1;
      k = 0;
      while (!s_axis_tready && k < 50) begin
        tick();
        k++;
      end
      if (k >= 50) check("beat_accept_timeout", k, 0);
      tick();
    end
    s_axis_tvalid = 1'b0;

    stall = 1'b0; held = '0; n_out = 0; got_first = 1'b0; aborted = 1'b0; k = 0;
    while (done_cnt == 0 && k < 400 && !aborted) begin
      if (stall) begin
        check("stall_valid", m_axis_tvalid, 1);
        check("stall_hold", {m_crop_idx, m_axis_tlast, m_axis_tdata}, held);
      end
      if (m_axis_tvalid && !got_first) begin
        got_first = 1'b1;
        if (bp_mode == 0) check("first_latency_ok", (cyc - rdy_cyc) <= 6, 1);
      end
      case (bp_mode)
        0:       tr = 1'b1;
        1:       tr = (k % 4 == 0) || (k % 4 == 3);
        default: tr = 1'($urandom_range(1, 0));
      endcase
      m_axis_tready = tr;
      if (m_axis_tvalid && tr) begin
        if (exp_q.size() == 0) check("extra_output", m_axis_tvalid, 0);
        else check("pixel", {m_crop_idx, m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
        n_out++;
      end
      stall = m_axis_tvalid && !tr;
      held = {m_crop_idx, m_axis_tlast, m_axis_tdata};
      tick();
      k++;
      if (abort_after > 0 && n_out == abort_after) aborted = 1'b1;
    end

    if (abort_after > 0) begin
      check("abort_reached", aborted, 1);
      reset = 1'b0;
      #1;
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_outs", {m_axis_tdata, m_axis_tlast, m_crop_idx, ap_done, ap_ready, crop_err}, 0);
      check("rst_idle", ap_idle, 1);
      check("rst_tready", s_axis_tready, 0);
      tick(); tick();
      reset = 1'b1;
      repeat (3) tick();
      check("no_done_after_abort", done_cnt, 0);
      check("idle_after_abort", ap_idle, 1);
    end else begin
      check("done_seen", done_cnt, 1);
      check("pixels_left", exp_q.size(), 0);
      check("ready_pulses", rdy_cnt, 1);
      tick();
      check("done_single", done_cnt, 1);
      check("idle_after_done", ap_idle, 1);
      check("crop_err_held", crop_err, exp_err);
`ifdef CROP_SUM_EN
      for (int i = 0; i < NUM_CROPS; i++) check("crop_sum", crop_sum[i*SW +: SW], exp_sum[i]);
`endif
    end
    m_axis_tready = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check("reset_idle", ap_idle, 1);
    check("reset_outs", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_crop_idx,
                         ap_done, ap_ready, crop_err, s_axis_tready}, 0);
    reset = 1'b1;
    tick();
    fill_img(1'b0);
    run_frame(3'b111, {3'd2, 3'd6, 3'd0}, {3'd3, 3'd6, 3'd0}, 0, 0, 0);
    run_frame(3'b101, {3'd7, 3'd6, 3'd0}, {3'd3, 3'd6, 3'd0}, 0, 0, 0);
    run_frame(3'b111, {3'd2, 3'd6, 3'd0}, {3'd3, 3'd6, 3'd0}, 0, 1, 0);
    run_frame(3'b111, {3'd2, 3'd6, 3'd0}, {3'd3, 3'd6, 3'd0}, 3, 0, 0);
    run_frame(3'b000, {3'd2, 3'd6, 3'd0}, {3'd3, 3'd6, 3'd0}, 0, 0, 0);
    run_frame(3'b111, {3'd2, 3'd6, 3'd0}, {3'd3, 3'd6, 3'd0}, 0, 0, 2);
    run_frame(3'b111, {3'd2, 3'd6, 3'd0}, {3'd3, 3'd6, 3'd0}, 0, 0, 0);
    for (int t = 0; t < 8; t++) begin
      fill_img(1'b1);
      run_frame(3'($urandom), 9'($urandom), 9'($urandom), -3, 2, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
